// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DROP
    } if_state_e;

    localparam logic [ILEN-1:0] NOP_INSTR       = 32'h0000_0000;
    localparam logic [XLEN-1:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched word and its PC+step while decode stalls.
module fetch_skid_buf
    import if_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            drain,
    input  logic            clear,
    input  logic [ILEN-1:0] load_data,
    input  logic [XLEN-1:0] load_pc,
    output logic [ILEN-1:0] data,
    output logic [XLEN-1:0] pc,
    output logic            full
);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            full <= 1'b0;
            data <= NOP_INSTR;
            pc   <= '0;
        end else if (load) begin
            full <= 1'b1;
            data <= load_data;
            pc   <= load_pc;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/instruct_fetch.sv
// Instruction fetch stage: PC, imem req/ready handshake and IF/ID register.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module instruct_fetch
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] PC_STEP  = 32'd4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            hazard_detected,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [ILEN-1:0] imem_rdata,
    output logic [ILEN-1:0] instruction,
    output logic [XLEN-1:0] pc_out,
    output logic            if_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_count,
    output logic [31:0]     stall_count,
    output logic [15:0]     flush_count
`endif
);

    if_state_e state, state_nxt;

    logic            active;
    logic [XLEN-1:0] pc, pc_nxt, pc_inc;
    logic [XLEN-1:0] redirect_pc, redirect_pc_nxt;
    logic [XLEN-1:0] target;
    logic            accept;

    logic            ifid_load;
    logic [ILEN-1:0] ifid_instr_nxt;
    logic [XLEN-1:0] ifid_pc_nxt;

    logic            skid_load, skid_drain, skid_full;
    logic [ILEN-1:0] skid_data;
    logic [XLEN-1:0] skid_pc;

    assign target    = word_align(br_target);
    assign pc_inc    = pc + PC_STEP;
    assign imem_addr = pc;
    assign imem_req  = active && (state != HOLD);
    assign accept    = imem_req && imem_ready;

    fetch_skid_buf u_skid (
        .clk       (clk),
        .reset     (reset),
        .load      (skid_load),
        .drain     (skid_drain),
        .clear     (br_taken),
        .load_data (imem_rdata),
        .load_pc   (pc_inc),
        .data      (skid_data),
        .pc        (skid_pc),
        .full      (skid_full)
    );

    // An unaccepted request cannot be withdrawn, so in DROP pc keeps the old
    // address on the bus and the branch target waits in redirect_pc.
    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        redirect_pc_nxt = redirect_pc;
        ifid_load       = 1'b0;
        ifid_instr_nxt  = imem_rdata;
        ifid_pc_nxt     = pc_inc;
        skid_load       = 1'b0;
        skid_drain      = 1'b0;

        if (br_taken) begin
            if (imem_req && !imem_ready) begin
                state_nxt       = DROP;
                redirect_pc_nxt = target;
            end else begin
                state_nxt = FETCH;
                pc_nxt    = target;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (accept) begin
                        pc_nxt = pc_inc;
                        if (hazard_detected) begin
                            skid_load = 1'b1;
                            state_nxt = HOLD;
                        end else begin
                            ifid_load = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!hazard_detected) begin
                        skid_drain     = 1'b1;
                        ifid_load      = skid_full;
                        ifid_instr_nxt = skid_data;
                        ifid_pc_nxt    = skid_pc;
                        state_nxt      = FETCH;
                    end
                end
                DROP: begin
                    if (imem_ready) begin
                        pc_nxt    = redirect_pc;
                        state_nxt = FETCH;
                    end
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            active      <= 1'b0;
            pc          <= RESET_PC;
            redirect_pc <= RESET_PC;
            instruction <= NOP_INSTR;
            pc_out      <= '0;
            if_valid    <= 1'b0;
        end else begin
            active      <= 1'b1;
            pc          <= pc_nxt;
            redirect_pc <= redirect_pc_nxt;
            if (br_taken) begin
                instruction <= NOP_INSTR;
                if_valid    <= 1'b0;
            end else if (ifid_load) begin
                instruction <= ifid_instr_nxt;
                pc_out      <= ifid_pc_nxt;
                if_valid    <= 1'b1;
            end else if (!hazard_detected) begin
                instruction <= NOP_INSTR;
                if_valid    <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_count <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (ifid_load && fetch_count != '1) fetch_count <= fetch_count + 32'd1;
            if (hazard_detected && stall_count != '1) stall_count <= stall_count + 32'd1;
            if (br_taken && flush_count != '1) flush_count <= flush_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruct_fetch.sv
// Self-checking bench for instruct_fetch against a queue-style fetch model.
module tb_instruct_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] STEP   = 32'd4;

    logic        clk = 1'b0;
    logic        reset, hazard_detected, br_taken, imem_ready;
    logic [31:0] br_target, imem_rdata;
    logic        imem_req, if_valid;
    logic [31:0] imem_addr, instruction, pc_out;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, stall_count;
    logic [15:0] flush_count;
`endif

    always #5 clk = ~clk;

    instruct_fetch #(.RESET_PC(RST_PC), .PC_STEP(STEP)) dut (
        .clk             (clk),
        .reset           (reset),
        .hazard_detected (hazard_detected),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .instruction     (instruction),
        .pc_out          (pc_out),
        .if_valid        (if_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count     (fetch_count),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
`endif
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [31:0] key      = '0;

    // Model: next address to request, an optional buffered word, and an
    // optional pending redirect whose in-flight response must be thrown away.
    logic        m_known = 1'b0;
    logic        m_started;
    logic [31:0] m_pc;
    logic [31:0] m_skid_q[$];
    logic [31:0] m_skid_pc_q[$];
    logic        m_discard;
    logic [31:0] m_discard_tgt;
    logic [31:0] m_instr, m_pcout;
    logic        m_valid;
    logic [31:0] m_fetch, m_stall, m_flush;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic bubble();
        m_instr = 32'h0;
        m_valid = 1'b0;
    endtask

    task automatic cyc(input logic rn, input logic hz, input logic br,
                       input logic [31:0] tgt, input logic rdy);
        logic        exp_req;
        logic [31:0] exp_addr, word;
        exp_req  = m_known && m_started && (m_skid_q.size() == 0);
        exp_addr = m_pc;
        word     = exp_addr ^ key;

        reset = rn; hazard_detected = hz; br_taken = br; br_target = tgt; imem_ready = rdy;
        imem_rdata = word;
        #2;
        if (m_known) begin
            chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
            chk("imem_addr", imem_addr, exp_addr);
        end
        @(posedge clk);

        if (!rn) begin
            m_known = 1'b1; m_started = 1'b0; m_pc = RST_PC;
            m_skid_q.delete(); m_skid_pc_q.delete();
            m_discard = 1'b0; m_discard_tgt = RST_PC;
            m_instr = 32'h0; m_pcout = 32'h0; m_valid = 1'b0;
            m_fetch = 0; m_stall = 0; m_flush = 0;
        end else if (m_known) begin
            if (hz && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (br && m_flush != 32'h0000_FFFF) m_flush++;
            if (br) begin
                bubble();
                m_skid_q.delete(); m_skid_pc_q.delete();
                if (exp_req && !rdy) begin
                    m_discard = 1'b1; m_discard_tgt = tgt & 32'hFFFF_FFFC;
                end else begin
                    m_discard = 1'b0; m_pc = tgt & 32'hFFFF_FFFC;
                end
            end else if (m_discard) begin
                if (rdy) begin m_discard = 1'b0; m_pc = m_discard_tgt; end
                if (!hz) bubble();
            end else if (m_skid_q.size() != 0) begin
                if (!hz) begin
                    m_instr = m_skid_q.pop_front(); m_pcout = m_skid_pc_q.pop_front();
                    m_valid = 1'b1; m_fetch++;
                end
            end else if (exp_req && rdy) begin
                m_pc = exp_addr + STEP;
                if (hz) begin
                    m_skid_q.push_back(word); m_skid_pc_q.push_back(exp_addr + STEP);
                end else begin
                    m_instr = word; m_pcout = exp_addr + STEP; m_valid = 1'b1; m_fetch++;
                end
            end else if (!hz) begin
                bubble();
            end
            m_started = 1'b1;
        end

        #1;
        if (m_known) begin
            chk("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
            chk("instruction", instruction, m_instr);
            if (m_valid) chk("pc_out", pc_out, m_pcout);
`ifdef FETCH_PERF_CNT_EN
            chk("fetch_count", fetch_count, m_fetch);
            chk("stall_count", stall_count, m_stall);
            chk("flush_count", {16'b0, flush_count}, m_flush);
`endif
        end
    endtask

    initial begin
        reset = 1'b0; hazard_detected = 1'b0; br_taken = 1'b0;
        br_target = '0; imem_ready = 1'b0; imem_rdata = '0;
        #1;
        // reset, then straight-line fetch with data == address
        cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 1);
        repeat (3) cyc(1, 0, 0, 0, 1);
        // three-cycle stall after word @8
        repeat (3) cyc(1, 1, 0, 0, 1);
        repeat (3) cyc(1, 0, 0, 0, 1);
        // taken branch while a word is accepted
        cyc(1, 0, 1, 32'h100, 1);
        repeat (3) cyc(1, 0, 0, 0, 1);
        // branch with an outstanding request -> discard path
        repeat (4) cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 1, 32'h40, 0);
        repeat (2) cyc(1, 0, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 1);
        // branch and stall together
        cyc(1, 1, 1, 32'h80, 1);
        repeat (2) cyc(1, 0, 0, 0, 1);
        // reset while holding a buffered word
        cyc(1, 1, 0, 0, 1); cyc(1, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        repeat (4) cyc(1, 0, 0, 0, 1);
        // unaligned target and address wrap-around
        cyc(1, 0, 1, 32'hFFFF_FFF7, 1);
        repeat (4) cyc(1, 0, 0, 0, 1);
        // branch while holding, branch re-targeted during discard
        cyc(1, 1, 0, 0, 1); cyc(1, 1, 1, 32'h200, 1);
        repeat (2) cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0); cyc(1, 0, 1, 32'h300, 0); cyc(1, 0, 1, 32'h400, 0);
        cyc(1, 0, 0, 0, 1);
        repeat (2) cyc(1, 0, 0, 0, 1);
        // reset during discard
        cyc(1, 0, 1, 32'h500, 0); cyc(0, 0, 0, 0, 1);
        repeat (3) cyc(1, 0, 0, 0, 1);

        key = $urandom;
        repeat (3000)
            cyc(($urandom % 100) != 0, ($urandom % 4) == 0, ($urandom % 6) == 0,
                $urandom, ($urandom % 3) != 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
